alu_cond_latch: RTL and testbench

// - Consumer end of the ALU compare units (ULE and siblings): accepts a compare result
//   (DATA_W-bit all-ones/all-zeros mask plus zero flag) over a valid/ready handshake.
// - Validates and decodes each result to a single taken bit, optionally inverted
//   (ULE -> UGT), and queues it for the branch/select unit in a DEPTH-entry FIFO.
// - Malformed results are flagged, never silently passed on as "taken".

---
 rtl/alu_pkg.sv | 15 +
 rtl/cond_fifo.sv | 61 ++++++
 rtl/alu_cond_latch.sv | 74 +++++++
 tb/tb_alu_cond_latch.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU compare-result consumers.
// Masks are classified by reduction so the helpers work for any mask width.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam logic [DATA_W_DEF-1:0] ALL_ONES = {DATA_W_DEF{1'b1}};

  // A result is well-formed when the mask is all-ones with flag low, or zero with flag high.
  function automatic logic is_wellformed(input logic mask_ones,
                                         input logic mask_zero,
                                         input logic flag);
    return (mask_ones && !flag) || (mask_zero && flag);
  endfunction

endpackage

// File: rtl/cond_fifo.sv
// Parametric synchronous FIFO with push/pop, occupancy count and a head-of-queue view.
// DEPTH must be a power of two so that the pointers wrap naturally.
module cond_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Guard locally as well, so the FIFO can never overflow or underflow on its own.
  assign do_push = push_i && (count_q != FULL_COUNT);
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_cond_latch.sv
// Decodes compare-unit masks into a single taken bit and queues them for the branch unit.
// Malformed masks are queued as not-taken and raise a sticky error flag.
module alu_cond_latch
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_mask,
  input  logic                       in_flag,
  input  logic                       in_invert,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_taken,
  output logic [DATA_W-1:0]          out_mask,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_malformed,
  input  logic                       err_clear
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic mask_ones, mask_zero, wellformed, taken_in;
  logic push, pop;
  logic head_taken;
  logic err_q, err_d;

  assign mask_ones  = &in_mask;
  assign mask_zero  = ~|in_mask;
  assign wellformed = is_wellformed(mask_ones, mask_zero, in_flag);
  // Invert only applies to well-formed results; malformed ones always store not-taken.
  assign taken_in   = wellformed & (mask_ones ^ in_invert);

  assign in_ready  = (count < FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  cond_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (taken_in),
    .dout_o  (head_taken),
    .count_o (count)
  );

  // Storage is not reset, so mask the head with out_valid.
  assign out_taken = out_valid & head_taken;
  assign out_mask  = {DATA_W{out_taken}};

  always_comb begin
    err_d = err_q;
    if (push && !wellformed) err_d = 1'b1;
    else if (err_clear)      err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_malformed = err_q;

endmodule

// File: tb/tb_alu_cond_latch.sv
// Directed and random checks of alu_cond_latch against a queue-based reference model.
module tb_alu_cond_latch;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_mask;
  logic              in_flag, in_invert;
  logic              out_valid, out_ready, out_taken;
  logic [DATA_W-1:0] out_mask;
  logic [CW-1:0]     count;
  logic              err_malformed, err_clear;

  bit q[$];
  bit m_err;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_cond_latch #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mask       (in_mask),
    .in_flag       (in_flag),
    .in_invert     (in_invert),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_taken     (out_taken),
    .out_mask      (out_mask),
    .count         (count),
    .err_malformed (err_malformed),
    .err_clear     (err_clear)
  );

  // Returns {malformed, taken} straight from the decode rules.
  function automatic logic [1:0] ref_decode(logic [DATA_W-1:0] m, logic f, logic inv);
    logic is_true, is_false;
    is_true  = (m == 32'hFFFF_FFFF) && (f == 1'b0);
    is_false = (m == 32'h0000_0000) && (f == 1'b1);
    if (is_true)  return {1'b0, ~inv};
    if (is_false) return {1'b0, inv};
    return 2'b10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit hd;
    hd = (q.size() != 0) ? q[0] : 1'b0;
    chk({tag, ":count"},     32'(count),         32'(q.size()));
    chk({tag, ":out_valid"}, 32'(out_valid),     32'(q.size() != 0));
    chk({tag, ":in_ready"},  32'(in_ready),      32'(q.size() < DEPTH));
    chk({tag, ":out_taken"}, 32'(out_taken),     32'(hd));
    chk({tag, ":out_mask"},  out_mask,           hd ? 32'hFFFF_FFFF : 32'h0);
    chk({tag, ":err"},       32'(err_malformed), 32'(m_err));
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] m, input logic f,
                       input logic inv, input logic ordy, input logic eclr);
    in_valid  = v;
    in_mask   = m;
    in_flag   = f;
    in_invert = inv;
    out_ready = ordy;
    err_clear = eclr;
  endtask

  task automatic cycle(input string tag);
    bit push, pop;
    logic [1:0] d;
    push = in_valid && (q.size() < DEPTH);
    pop  = out_ready && (q.size() != 0);
    d    = ref_decode(in_mask, in_flag, in_invert);
    @(posedge clk);
    #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d[0]);
    if (push && d[1])   m_err = 1'b1;
    else if (err_clear) m_err = 1'b0;
    if (push || pop)
      $display("[TB] %s t=%0t push=%0b pop=%0b mask=%h flag=%0b inv=%0b count=%0d",
               tag, $time, push, pop, in_mask, in_flag, in_invert, q.size());
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle("idle");

    // Two well-formed pushes, then drain.
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0); cycle("push_true");
    drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);         cycle("push_false_inv");
    chk("two_count", 32'(count), 32'd2);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop0_taken", 32'(out_taken), 32'd1);
    chk("pop0_mask", out_mask, 32'hFFFF_FFFF);
    cycle("pop0");
    chk("pop1_taken", 32'(out_taken), 32'd1);
    chk("pop1_mask", out_mask, 32'hFFFF_FFFF);
    cycle("pop1");

    // Fill to full, hold a fifth request, then free one slot.
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0); cycle("fill0");
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);         cycle("fill1");
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0); cycle("fill2");
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0); cycle("fill3");
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);         cycle("held5");
    chk("held5_count", 32'(count), 32'd4);
    drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);         cycle("full_pop");
    chk("full_pop_count", 32'(count), 32'd3);
    drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);         cycle("accept5");
    chk("accept5_count", 32'(count), 32'd4);

    // Drain to two, then concurrent push/pop long enough to wrap the pointers.
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0); cycle("drain_a"); cycle("drain_b");
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0, (i % 2 == 0) ? 1'b0 : 1'b1,
            (i % 3 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      cycle("pushpop");
      chk("pushpop_count", 32'(count), 32'd2);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0); cycle("drain_c"); cycle("drain_d");

    // Malformed entries and sticky error behaviour.
    drive(1'b1, 32'h0000_FFFF, 1'b0, 1'b1, 1'b0, 1'b0); cycle("malformed");
    chk("malformed_err", 32'(err_malformed), 32'd1);
    chk("malformed_taken", 32'(out_taken), 32'd0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);         cycle("clear_vs_set");
    chk("set_wins", 32'(err_malformed), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);            cycle("clear");
    chk("cleared", 32'(err_malformed), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);            cycle("drain_e");

    // Asynchronous reset with three queued entries.
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("pre_rst0"); cycle("pre_rst1"); cycle("pre_rst2");
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_err = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst");

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      logic [DATA_W-1:0] m;
      logic f;
      case ($urandom_range(0, 5))
        0, 1:    begin m = 32'hFFFF_FFFF; f = 1'b0; end
        2, 3:    begin m = 32'h0;         f = 1'b1; end
        4:       begin m = 32'($urandom); f = 1'($urandom); end
        default: begin m = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0; f = 1'($urandom); end
      endcase
      drive(1'($urandom), m, f, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
